mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 12 +
 rtl/mem_arbiter_rr_pick2.sv | 11 +
 rtl/mem_arbiter.sv | 88 ++++++++
 tb/tb_mem_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN_P0, OWN_P1, OWN_P1_LOCKED} owner_e;
  localparam int LOCK_MAX = 4;
  localparam int LCW = 3;
  typedef logic port_t;
  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;
  function automatic logic [1:0] port_oh(port_t p);
    return p ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin choice, the port not granted last wins a tie
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic  [1:0] req_i,
  input  port_t       last_i,
  output logic  [1:0] gnt_o
);
  // a lone request wins outright; a tie goes to the port that did not win last
  always_comb gnt_o = (req_i == 2'b11) ? port_oh(~last_i) : req_i;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port single-RAM arbiter with round robin and a bounded p1 lock
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int D = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         p0_req,
  input  logic         p1_req,
  input  logic         p0_we,
  input  logic         p1_we,
  input  logic [D-1:0] p0_addr,
  input  logic [D-1:0] p1_addr,
  input  logic [W-1:0] p0_wdata,
  input  logic [W-1:0] p1_wdata,
  input  logic         p1_lock,
  output logic         p0_gnt,
  output logic         p1_gnt,
  output logic         p0_rvalid,
  output logic         p1_rvalid,
  output logic [W-1:0] rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [D-1:0] mem_addr,
  output logic [W-1:0] mem_din,
  input  logic [W-1:0] mem_dout
);
  owner_e         state_q, state_d;
  port_t          last_q, last_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]     rr_gnt, gnt, rvalid_q, rvalid_d;
  logic [W-1:0]   rdata_q, rdata_d;
  logic           lock_hold;

  rr_pick2 u_rr (
    .req_i  ({p1_req, p0_req}),
    .last_i (last_q),
    .gnt_o  (rr_gnt)
  );

  // grant decision, owner next state, lock budget and RAM port steering
  always_comb begin
    lock_hold  = state_q == OWN_P1_LOCKED && p1_req && lock_cnt_q < LCW'(LOCK_MAX);
    gnt        = reset ? 2'b00 : lock_hold ? 2'b10 : rr_gnt;
    state_d    = gnt[0] ? OWN_P0 : gnt[1] ? (p1_lock ? OWN_P1_LOCKED : OWN_P1) : IDLE;
    last_d     = gnt[0] ? PORT0 : gnt[1] ? PORT1 : last_q;
    lock_cnt_d = (gnt[1] && p1_lock && state_q == OWN_P1_LOCKED)
               ? (lock_cnt_q < LCW'(LOCK_MAX) ? lock_cnt_q + LCW'(1) : lock_cnt_q) : '0;
    mem_read   = (gnt[0] & ~p0_we) | (gnt[1] & ~p1_we);
    mem_write  = (gnt[0] & p0_we) | (gnt[1] & p1_we);
    mem_addr   = gnt[0] ? p0_addr : gnt[1] ? p1_addr : '0;
    mem_din    = gnt[0] ? p0_wdata : gnt[1] ? p1_wdata : '0;
    rvalid_d   = {gnt[1] & ~p1_we, gnt[0] & ~p0_we};
    rdata_d    = mem_read ? mem_dout : rdata_q;
  end

  // owner state, round-robin pointer and lock budget
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= PORT1;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // one-cycle read return path; holds the last read word between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid_q[0] & ~reset;
  assign p1_rvalid = rvalid_q[1] & ~reset;
  assign rdata     = reset ? '0 : rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed scoreboard bench against a behavioural arbiter model
module tb_mem_arbiter;
  localparam int D = 8, W = 8;
  logic clk = 0, reset = 1;
  logic p0_req = 0, p1_req = 0, p0_we = 0, p1_we = 0, p1_lock = 0;
  logic [D-1:0] p0_addr = 0, p1_addr = 0;
  logic [W-1:0] p0_wdata = 0, p1_wdata = 0;
  logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_read, mem_write;
  logic [W-1:0] rdata, mem_din, mem_dout;
  logic [D-1:0] mem_addr;
  logic [W-1:0] ram [256];
  logic [W-1:0] init_val [256];
  logic [W-1:0] mram [256];
  int cyc = 0, errors = 0, checks = 0;
  int m_last = 1, m_streak = 0;
  bit m_lkprev = 0;
  logic [W-1:0] exp_rdata = 0;

  typedef struct { logic [1:0] gnt; logic rd, wr; logic [7:0] addr, din; } gexp_t;
  typedef struct { int cyc; logic [1:0] rv; logic [7:0] data; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  mem_arbiter #(.D(D), .W(W)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid), .rdata(rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_dout = ram[mem_addr];
  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 256; i++) ram[i] <= init_val[i];
    else if (mem_write) ram[mem_addr] <= mem_din;
  end

  task automatic drive(input bit rs, input bit r0, input bit w0, input logic [7:0] a0,
                       input logic [7:0] d0, input bit r1, input bit w1, input logic [7:0] a1,
                       input logic [7:0] d1, input bit lk);
    gexp_t g;
    rexp_t r;
    int win;
    bit we;
    @(posedge clk); #1;
    reset = rs; p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_lock = lk;
    win = -1;
    if (rs) begin
      m_last = 1; m_streak = 0; m_lkprev = 0;
      rq.delete();
      for (int i = 0; i < 256; i++) mram[i] = init_val[i];
    end else begin
      if (r0 && !r1) win = 0;
      else if (r1 && !r0) win = 1;
      else if (r0 && r1) win = (m_lkprev && m_streak < 4) ? 1 : 1 - m_last;
      if (win == 1 && lk) begin
        m_streak = m_lkprev ? (m_streak < 4 ? m_streak + 1 : 4) : 0;
        m_lkprev = 1;
      end else begin
        m_streak = 0;
        m_lkprev = 0;
      end
      if (win >= 0) m_last = win;
    end
    g = '{gnt: 2'b00, rd: 1'b0, wr: 1'b0, addr: 8'h00, din: 8'h00};
    if (win >= 0) begin
      we = win == 1 ? w1 : w0;
      g.gnt = win == 1 ? 2'b10 : 2'b01;
      g.addr = win == 1 ? a1 : a0;
      g.din = win == 1 ? d1 : d0;
      g.rd = ~we;
      g.wr = we;
      if (we) mram[g.addr] = g.din;
      else begin
        r = '{cyc: cyc + 1, rv: g.gnt, data: mram[g.addr]};
        rq.push_back(r);
      end
    end
    gq.push_back(g);
  endtask

  task automatic idle(input bit rs);
    drive(rs, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
  endtask

  always @(negedge clk) begin
    gexp_t e;
    rexp_t r;
    logic [1:0] erv;
    if (gq.size() > 0) begin
      e = gq.pop_front();
      checks++;
      if ({p1_gnt, p0_gnt} !== e.gnt || mem_read !== e.rd || mem_write !== e.wr ||
          mem_addr !== e.addr || mem_din !== e.din) begin
        errors++;
        $display("FAIL grant cyc=%0d got gnt=%b rd=%b wr=%b addr=%h din=%h exp gnt=%b rd=%b wr=%b addr=%h din=%h",
                 cyc, {p1_gnt, p0_gnt}, mem_read, mem_write, mem_addr, mem_din,
                 e.gnt, e.rd, e.wr, e.addr, e.din);
      end
      erv = 2'b00;
      if (reset) exp_rdata = 0;
      else if (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        erv = r.rv;
        exp_rdata = r.data;
      end
      checks++;
      if ({p1_rvalid, p0_rvalid} !== erv || rdata !== exp_rdata) begin
        errors++;
        $display("FAIL readback cyc=%0d got rvalid=%b rdata=%h exp rvalid=%b rdata=%h",
                 cyc, {p1_rvalid, p0_rvalid}, rdata, erv, exp_rdata);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) init_val[i] = 8'($urandom);
    init_val[8'h10] = 8'hA5;
    init_val[8'h20] = 8'h00;
    idle(1); idle(1);
    drive(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    idle(0);
    idle(1);
    for (int i = 0; i < 6; i++)
      drive(0, 1, 0, 8'($urandom), 8'($urandom), 1, 0, 8'($urandom), 8'($urandom), 0);
    drive(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 0);
    drive(0, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    drive(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 1);
    for (int i = 0; i < 7; i++)
      drive(0, 1, 0, 8'($urandom_range(0, 15)), 8'h00, 1, 0, 8'($urandom_range(0, 15)), 8'h00, 1);
    drive(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    idle(1);
    idle(0); idle(0); idle(0);
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
            8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 9) < 7, 1'($urandom),
            8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 2) != 0);
    idle(0); idle(0);
    @(negedge clk); #1;
    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL drain got pending_reads=%0d exp 0", rq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
